// File: rtl/muldiv_sequencer_if.sv
// Signal bundle joining the decoder/register file, hilo register and PC to the
// multiply/divide sequencer. The decoder side is the master.
interface muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        stall;
  logic        busy;
  logic        hilo_wr_en;
  logic [63:0] hilo_wr_data;
  logic        div_by_zero;

  modport master (
    output start, op, rs, rt,
    input  stall, busy, hilo_wr_en, hilo_wr_data, div_by_zero
  );

  modport slave (
    input  start, op, rs, rt,
    output stall, busy, hilo_wr_en, hilo_wr_data, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the HI/LO path, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the multiplier is exhausted.
module muldiv_sequencer (
  input  logic              clk_cpu,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  logic [1:0]  r_state;
  logic [5:0]  r_count;
  logic [1:0]  r_op;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_rt_zero;
  logic [31:0] r_rs;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_divisor;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic        r_wr_en;
  logic        r_dbz;
  logic [63:0] r_hilo;

  logic        w_accept;
  logic        w_is_div;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [31:0] w_mplier_next;
  logic [63:0] w_acc_next;
  logic [33:0] w_rem_diff;
  logic        w_rem_ge;
  logic        w_calc_last;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_remv;
  logic [63:0] w_result;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_is_div = r_op[1];

  // Signed ops work on magnitudes; the signs are restored in FIX.
  assign w_rs_neg = ~bus.op[0] & bus.rs[31];
  assign w_rt_neg = ~bus.op[0] & bus.rt[31];
  assign w_rs_mag = w_rs_neg ? (~bus.rs + 32'd1) : bus.rs;
  assign w_rt_mag = w_rt_neg ? (~bus.rt + 32'd1) : bus.rt;

  assign w_mplier_next = {1'b0, r_mplier[31:1]};
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Restoring step: shift the next dividend bit in and try to subtract the divisor.
  assign w_rem_diff = {r_rem, r_mplier[31]} - {2'b00, r_divisor};
  assign w_rem_ge   = ~w_rem_diff[33];

`ifdef MULDIV_EARLY_OUT_EN
  assign w_calc_last = (r_count == 6'd1) || (!w_is_div && (w_mplier_next == 32'd0));
`else
  assign w_calc_last = (r_count == 6'd1);
`endif

  always_comb begin
    w_prod   = r_acc;
    w_quo    = r_mplier;
    w_remv   = r_rem[31:0];
    w_result = r_acc;
    if ((r_op == OP_MULT) && (r_neg_a ^ r_neg_b)) begin
      w_prod = ~r_acc + 64'd1;
    end
    if ((r_op == OP_DIV) && (r_neg_a ^ r_neg_b)) begin
      w_quo = ~r_mplier + 32'd1;
    end
    if ((r_op == OP_DIV) && r_neg_a) begin
      w_remv = ~r_rem[31:0] + 32'd1;
    end
    if (!w_is_div) begin
      w_result = w_prod;
    end else if (r_rt_zero) begin
      w_result = {r_rs, 32'hFFFF_FFFF};
    end else begin
      w_result = {w_remv, w_quo};
    end
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_CALC;
            r_count <= 6'd32;
          end
        end
        S_CALC: begin
          r_count <= r_count - 6'd1;
          if (w_calc_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX:   r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_mplier carries the multiplier (shifting right) or the dividend turning into the quotient (shifting left).
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      r_op      <= 2'b00;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_rt_zero <= 1'b0;
      r_rs      <= 32'd0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_divisor <= 32'd0;
      r_acc     <= 64'd0;
      r_rem     <= 33'd0;
    end else if (w_accept) begin
      r_op      <= bus.op;
      r_neg_a   <= w_rs_neg;
      r_neg_b   <= w_rt_neg;
      r_rt_zero <= (bus.rt == 32'd0);
      r_rs      <= bus.rs;
      r_mcand   <= {32'd0, w_rs_mag};
      r_mplier  <= bus.op[1] ? w_rs_mag : w_rt_mag;
      r_divisor <= w_rt_mag;
      r_acc     <= 64'd0;
      r_rem     <= 33'd0;
    end else if (r_state == S_CALC) begin
      if (w_is_div) begin
        r_rem    <= w_rem_ge ? w_rem_diff[32:0] : {r_rem[31:0], r_mplier[31]};
        r_mplier <= {r_mplier[30:0], w_rem_ge};
      end else begin
        r_acc    <= w_acc_next;
        r_mcand  <= {r_mcand[62:0], 1'b0};
        r_mplier <= w_mplier_next;
      end
    end
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      r_wr_en <= 1'b0;
      r_dbz   <= 1'b0;
      r_hilo  <= 64'd0;
    end else begin
      r_wr_en <= (r_state == S_FIX);
      r_dbz   <= (r_state == S_FIX) && w_is_div && r_rt_zero;
      if (r_state == S_FIX) begin
        r_hilo <= w_result;
      end
    end
  end

  // stall is gated by reset so the PC is released the moment reset is applied.
  assign bus.stall        = reset & (w_accept | (r_state == S_CALC) | (r_state == S_FIX));
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.hilo_wr_en   = r_wr_en;
  assign bus.div_by_zero  = r_dbz;
  assign bus.hilo_wr_data = r_hilo;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the 32-bit CPU's HI/LO path. It takes over the MULT/MULTU/DIV/DIVU work from the single-cycle ALU and computes the result iteratively, one bit per cycle. While it runs it stalls the program counter, then writes the 64-bit result into the hilo register with a single write pulse. It sits between the decoder/register file (operands, start), the hilo register (write port) and the program counter (stall).

## Interface

No parameters.

- clk_cpu  in  1  CPU clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  decoder asserts this for a mult/div instruction; level, held while the instruction is current
- op  in  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
- rs  in  32  operand A (multiplicand / dividend)
- rt  in  32  operand B (multiplier / divisor)
- stall  out  1  holds the PC and register writes while high
- busy  out  1  high in every state except IDLE
- hilo_wr_en  out  1  one-cycle write strobe to the hilo register
- hilo_wr_data  out  64  {HI, LO} result
- div_by_zero  out  1  pulses together with hilo_wr_en when a divide had rt == 0

## Operation

- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - start=1 → latch op, the operand magnitudes (absolute values for MULT/DIV, raw for MULTU/DIVU) and the sign flags.
  - Clear the accumulator, set the 6-bit counter to 32, go to CALC.
  - start=0 → stay in IDLE.
- **CALC, multiply:** radix-2 shift-add, one multiplier bit per cycle, into a 64-bit product register.
- **CALC, divide:** restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- **CALC, counter:** decrements each cycle; at 1, go to FIX.
- **FIX: sign correction.**
  - MULT: product negated if the operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Result: HI = remainder, LO = quotient.
  - Divide with rt == 0 (signed or unsigned): result forced to HI = rs as latched, LO = 32'hFFFF_FFFF; div_by_zero flag set.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0, no flag.
- **DONE:** hilo_wr_en=1, and div_by_zero=1 if flagged. Always go to IDLE next; start is ignored in DONE.
- start during CALC/FIX/DONE is ignored; op/rs/rt changes after acceptance have no effect.
- Reset (any state, mid-operation included): state IDLE, counter 0, all outputs 0, no hilo write, and the result register cleared.

## Timing

- **Acceptance:** edge E0 is the first rising edge with state IDLE and start=1.
- **Cycle counts:** CALC spans E0..E32 (32 cycles), FIX E32..E33, DONE E33..E34. hilo_wr_en is high for exactly the cycle between E33 and E34, and the hilo register captures at E34.
- **stall** = (IDLE & start) | CALC | FIX. It is combinational from start in IDLE, so the instruction is held from its first cycle.
  - stall is low in DONE, so the PC advances at E34, the same edge as the hilo write.
- **busy** is high from E0 to E34.
- **Back-to-back:** a following mult/div instruction sees IDLE after E34 and is accepted at E35.
- **Registered outputs:** hilo_wr_data is valid whenever hilo_wr_en=1 and holds its value until the next FIX. hilo_wr_en and div_by_zero are registered.

## Configuration

- `MULDIV_EARLY_OUT_EN` defined:
  - Multiply leaves CALC at the end of the first CALC cycle in which the remaining multiplier bits are all zero.
  - The minimum is one CALC cycle, so rt=0 writes at E2 + 1 cycle (FIX at E1, DONE at E2).
  - Divide is unaffected (always 32 cycles).
- Not defined: every operation uses a fixed 32 CALC cycles, with timing exactly as above.

## Test plan

- **MULTU:** rs=32'hFFFF_FFFF, rt=32'hFFFF_FFFF, start held → stall high E0..E33. hilo_wr_data=64'hFFFF_FFFE_0000_0001 with hilo_wr_en high only between E33 and E34.
- **MULT:** rs=-7, rt=6 → {HI,LO}=64'hFFFF_FFFF_FFFF_FFD6. DIV rs=-7, rt=2 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFD.
- **Divide by zero:** DIVU rs=32'h1234, rt=0 → HI=32'h1234, LO=32'hFFFF_FFFF, div_by_zero=1 in the same cycle as hilo_wr_en.
- **Overflow:** DIV rs=32'h8000_0000, rt=32'hFFFF_FFFF → LO=32'h8000_0000, HI=0, div_by_zero=0.
- **Reset mid-operation:** reset=0 at cycle 10 of CALC → stall/busy/hilo_wr_en drop immediately, no write pulse follows. After release, start is accepted on the first edge.
- **Back-to-back and early-out:** two consecutive MULTU instructions → second accepted at E35, exactly one hilo_wr_en per operation. With `MULDIV_EARLY_OUT_EN`, rt=3 → hilo_wr_en 4 cycles after E0 (CALC 2 cycles, FIX, DONE).
